// File: rtl/pipeline_run_controller.sv
// Pipeline run controller: debug-driven run/step/halt sequencing with per-cycle
// stall/flush generation and cycle/stall counters for the debug unit.
module pipeline_run_controller #(
    parameter int unsigned COUNT_WIDTH   = 32,
    parameter bit          START_RUNNING = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_use_hazard,
    input  logic                   branch_taken_ID,
    input  logic                   halt_instr_WB,
    input  logic                   debug_cmd_valid,
    input  logic [1:0]             debug_cmd,
    output logic                   debug_cmd_ready,
    output logic                   PC_write,
    output logic                   IF_ID_write,
    output logic                   pipe_write,
    output logic                   mux_ctrl_signal_sel,
    output logic                   IF_ID_flush,
    output logic                   halted,
    output logic [1:0]             state,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_RUN  = 2'b01,
        CMD_STEP = 2'b10,
        CMD_HALT = 2'b11
    } cmd_e;

    state_e                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic [COUNT_WIDTH-1:0] stall_count_q, stall_count_d;
    logic                   enabled;
    cmd_e                   cmd;

    assign cmd = cmd_e'(debug_cmd);

    always_comb begin
        enabled             = (state_q == RUN) || (state_q == STEP);
        PC_write            = 1'b0;
        IF_ID_write         = 1'b0;
        pipe_write          = 1'b0;
        mux_ctrl_signal_sel = 1'b1;
        IF_ID_flush         = 1'b0;
        debug_cmd_ready     = 1'b0;
        state_d             = state_q;

        if (enabled) begin
            pipe_write          = 1'b1;
            PC_write            = !load_use_hazard;
            IF_ID_write         = !load_use_hazard;
            mux_ctrl_signal_sel = !load_use_hazard;
            // A stalled branch re-resolves next cycle, so its flush waits too.
            IF_ID_flush         = branch_taken_ID && !load_use_hazard;
        end

        case (state_q)
            IDLE: begin
                if (debug_cmd_valid && cmd == CMD_RUN) begin
                    state_d         = RUN;
                    debug_cmd_ready = 1'b1;
                end else if (debug_cmd_valid && cmd == CMD_STEP) begin
                    state_d         = STEP;
                    debug_cmd_ready = 1'b1;
                end
            end
            RUN: begin
                if (halt_instr_WB) begin
                    state_d = DONE;
                end else if (debug_cmd_valid && cmd == CMD_HALT) begin
                    state_d         = IDLE;
                    debug_cmd_ready = 1'b1;
                end
            end
            STEP: begin
                state_d = halt_instr_WB ? DONE : IDLE;
            end
            default: begin
                state_d = DONE;
            end
        endcase

        cycle_count_d = cycle_count_q + COUNT_WIDTH'(pipe_write);
        stall_count_d = stall_count_q + COUNT_WIDTH'(enabled && load_use_hazard);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= START_RUNNING ? RUN : IDLE;
            cycle_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign halted      = (state_q == DONE);
    assign state       = state_q;
    assign cycle_count = cycle_count_q;
    assign stall_count = stall_count_q;

endmodule
